// File: rtl/alarm_controller.sv
// Alarm sequencer: ringing, snooze and auto-timeout policy, plus the buzzer beep pattern.
// All outputs are registered and reflect the state being entered on each clk edge.
module alarm_controller #(
    parameter  int SNOOZE_SEC       = 300,
    parameter  int RING_TIMEOUT_SEC = 60,
    parameter  int MAX_SNOOZES      = 3,
    localparam int CW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_1hz,
    input  logic          time_match,
    input  logic          alarm_enable,
    input  logic          snooze_btn,
    input  logic          stop_btn,
    output logic          alarm_on,
    output logic          buzzer,
    output logic          snoozing,
    output logic [CW-1:0] snooze_count
);

    localparam int RW = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);
    localparam logic [CW-1:0] SNZ_MAX   = CW'(MAX_SNOOZES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
    logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
    logic [CW-1:0]   snooze_count_q, snooze_count_d;
    logic            buzzer_q, buzzer_d;
    logic            alarm_on_q, alarm_on_d;
    logic            snoozing_q, snoozing_d;
    logic            time_match_q;
    logic            match_rise;
    logic            snooze_ok;

    assign match_rise = time_match & ~time_match_q;
    assign snooze_ok  = snooze_btn && (snooze_count_q < SNZ_MAX);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snz_cnt_d      = snz_cnt_q;
        snooze_count_d = snooze_count_q;
        buzzer_d       = buzzer_q;

        if (!alarm_enable) begin
            state_d        = IDLE;
            ring_cnt_d     = '0;
            snz_cnt_d      = '0;
            snooze_count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match_rise) begin
                        state_d        = RINGING;
                        ring_cnt_d     = '0;
                        buzzer_d       = 1'b1;
                        snooze_count_d = '0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_d        = DONE;
                        snooze_count_d = '0;
                    end else if (snooze_ok) begin
                        state_d        = SNOOZE;
                        snooze_count_d = snooze_count_q + CW'(1);
                        snz_cnt_d      = '0;
                    end else if (tick_1hz) begin
                        buzzer_d = ~buzzer_q;
                        if (ring_cnt_q == RING_LAST) begin
                            state_d        = DONE;
                            snooze_count_d = '0;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RW'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d        = DONE;
                        snooze_count_d = '0;
                    end else if (tick_1hz) begin
                        if (snz_cnt_q == SNZ_LAST) begin
                            state_d    = RINGING;
                            ring_cnt_d = '0;
                            buzzer_d   = 1'b1;
                        end else begin
                            snz_cnt_d = snz_cnt_q + SW'(1);
                        end
                    end
                end
                DONE: begin
                    // Wait out the matching minute so the same match cannot re-trigger.
                    if (!time_match) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the state being entered, so they are valid with it.
        if (state_d != RINGING) buzzer_d = 1'b0;
        alarm_on_d = (state_d == RINGING) || (state_d == SNOOZE);
        snoozing_d = (state_d == SNOOZE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            ring_cnt_q     <= '0;
            snz_cnt_q      <= '0;
            snooze_count_q <= '0;
            buzzer_q       <= 1'b0;
            alarm_on_q     <= 1'b0;
            snoozing_q     <= 1'b0;
            time_match_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snz_cnt_q      <= snz_cnt_d;
            snooze_count_q <= snooze_count_d;
            buzzer_q       <= buzzer_d;
            alarm_on_q     <= alarm_on_d;
            snoozing_q     <= snoozing_d;
            time_match_q   <= time_match;
        end
    end

    assign alarm_on     = alarm_on_q;
    assign buzzer       = buzzer_q;
    assign snoozing     = snoozing_q;
    assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with SNOOZE_SEC=5, RING_TIMEOUT_SEC=4, MAX_SNOOZES=2.
// Expected outputs are packed as {alarm_on, buzzer, snoozing, snooze_count[1:0]}.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       time_match;
    logic       alarm_enable;
    logic       snooze_btn;
    logic       stop_btn;
    logic       alarm_on;
    logic       buzzer;
    logic       snoozing;
    logic [1:0] snooze_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       match;
        logic       tick;
        logic       snz;
        logic       stop;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    alarm_controller #(
        .SNOOZE_SEC      (5),
        .RING_TIMEOUT_SEC(4),
        .MAX_SNOOZES     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .time_match  (time_match),
        .alarm_enable(alarm_enable),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .alarm_on    (alarm_on),
        .buzzer      (buzzer),
        .snoozing    (snoozing),
        .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic add(input logic rst_n, en, match, tick, snz, stop, input logic [4:0] exp);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.match = match;
        v.tick = tick; v.snz = snz; v.stop = stop; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst_n, en, match, tick, snz, stop);
        reset = rst_n; alarm_enable = en; time_match = match;
        tick_1hz = tick; snooze_btn = snz; stop_btn = stop;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {3'b000, alarm_on, buzzer, snoozing, snooze_count};
    endfunction

    initial begin
        int ring_at;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //   rst en  mt  tk  sz  st   {on,bz,sg,cnt}
        add(0, 0, 0, 0, 0, 0, 5'b00000); // reset state
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000); // match rise -> ring
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b11000);
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b00000); // 4th tick -> timeout
        add(1, 1, 1, 0, 0, 0, 5'b00000); // DONE holds while matching
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000); // fresh rise re-rings
        add(1, 1, 1, 0, 1, 0, 5'b10101); // snooze #1
        add(1, 1, 1, 1, 0, 0, 5'b10101);
        add(1, 1, 1, 1, 0, 0, 5'b10101);
        add(1, 1, 1, 1, 0, 0, 5'b10101);
        add(1, 1, 1, 1, 0, 0, 5'b10101);
        add(1, 1, 1, 1, 0, 0, 5'b11001); // 5th tick -> ring again
        add(1, 1, 1, 0, 1, 0, 5'b10110); // snooze #2
        add(1, 1, 1, 1, 0, 0, 5'b10110);
        add(1, 1, 1, 1, 0, 0, 5'b10110);
        add(1, 1, 1, 1, 0, 0, 5'b10110);
        add(1, 1, 1, 1, 0, 0, 5'b10110);
        add(1, 1, 1, 1, 0, 0, 5'b11010);
        add(1, 1, 1, 0, 1, 0, 5'b11010); // third snooze ignored
        add(1, 1, 1, 1, 1, 0, 5'b10010); // ignored snooze, tick still toggles
        add(1, 1, 1, 0, 1, 1, 5'b00000); // stop wins over snooze
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 0, 1, 0, 0, 0, 5'b00000); // match already high while disabled
        add(1, 1, 1, 0, 0, 0, 5'b00000); // enable rise alone does not trigger
        add(1, 1, 1, 0, 0, 0, 5'b00000);
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 0, 1, 0, 5'b10101);
        add(1, 0, 1, 0, 0, 0, 5'b00000); // disable in SNOOZE -> IDLE
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(0, 1, 1, 0, 0, 0, 5'b00000); // reset mid-ring
        add(1, 1, 1, 0, 0, 0, 5'b11000); // match_q cleared, rings again
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b00000); // full 4 ticks to timeout
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 0, 1, 0, 5'b10101);
        add(0, 1, 1, 0, 0, 0, 5'b00000); // reset mid-snooze
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 1, 5'b00000); // stop with timeout tick
        add(1, 1, 0, 0, 0, 0, 5'b00000);
        add(1, 1, 1, 0, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 0, 0, 5'b11000);
        add(1, 1, 1, 1, 0, 0, 5'b10000);
        add(1, 1, 1, 1, 1, 0, 5'b10101); // snooze beats timeout tick
        add(1, 1, 1, 0, 0, 1, 5'b00000);
        add(1, 1, 0, 0, 0, 0, 5'b00000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].match,
                  vecs[i].tick, vecs[i].snz, vecs[i].stop);
            step();
            check($sformatf("vec%0d", i), outs(), {3'b000, vecs[i].exp});
        end

        // Snooze presses during SNOOZE are ignored; re-ring lands on the 5th tick.
        drive(1, 1, 1, 0, 0, 0); step();
        check("seq ring", outs(), 8'b00011000);
        drive(1, 1, 1, 0, 1, 0); step();
        check("seq snooze", outs(), 8'b00010101);
        ring_at = 0;
        for (int i = 1; i <= 20 && ring_at == 0; i++) begin
            drive(1, 1, 1, 1, (i <= 2), 0);
            step();
            if (buzzer === 1'b1) ring_at = i;
        end
        check("seq rering tick", 8'(ring_at), 8'd5);
        check("seq rering outs", outs(), 8'b00011001);

        // Stop, then ticks in DONE must leave buzzer and alarm_on low.
        drive(1, 1, 1, 0, 0, 1); step();
        check("seq stop", outs(), 8'b00000000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 0, 0); step();
            check($sformatf("seq done tick%0d", i), outs(), 8'b00000000);
        end
        drive(1, 1, 0, 0, 0, 0); step();
        drive(1, 1, 1, 0, 0, 0); step();
        check("seq rearm", outs(), 8'b00011000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
